// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and the LSU.
// One transaction in flight; the response returns MEM_LAT cycles after the grant.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned MEM_LAT    = 1,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [DATA_W-1:0]     if_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [DATA_W/8-1:0]   d_wstrb,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_W-1:0]     d_rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [DATA_W/8-1:0]   mem_wstrb,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata
);

    localparam int unsigned LAT_W    = 2;
    localparam int unsigned STARVE_W = $clog2(STARVE_MAX + 1);

    if (MEM_LAT < 1 || MEM_LAT > 4) begin : g_bad_lat
        $error("mem_port_arbiter: MEM_LAT=%0d outside supported range 1..4", MEM_LAT);
    end

    typedef enum logic {IDLE, WAIT} state_t;

    state_t              state_q, state_d;
    logic [LAT_W-1:0]    lat_q, lat_d;
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic                owner_d_q, owner_d_d;   // 1: LSU owns the in-flight access
    logic                wr_q, wr_d;             // in-flight access is a write
    logic                fetch_win;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            lat_q     <= '0;
            starve_q  <= '0;
            owner_d_q <= 1'b0;
            wr_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            lat_q     <= lat_d;
            starve_q  <= starve_d;
            owner_d_q <= owner_d_d;
            wr_q      <= wr_d;
        end
    end

    // Arbitration, memory strobe and response steering; everything is silenced in reset.
    always_comb begin
        state_d   = state_q;
        lat_d     = lat_q;
        starve_d  = starve_q;
        owner_d_d = owner_d_q;
        wr_d      = wr_q;
        fetch_win = 1'b0;
        if_gnt    = 1'b0;
        if_rvalid = 1'b0;
        if_rdata  = '0;
        d_gnt     = 1'b0;
        d_rvalid  = 1'b0;
        d_rdata   = '0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_wstrb = '0;
        mem_addr  = '0;
        mem_wdata = '0;

        if (!reset) begin
            case (state_q)
                IDLE: begin
                    if (if_req || d_req) begin
                        fetch_win = if_req && (!d_req || starve_q == STARVE_W'(STARVE_MAX));
                        mem_en    = 1'b1;
                        state_d   = WAIT;
                        lat_d     = LAT_W'(MEM_LAT - 1);
                        if (fetch_win) begin
                            if_gnt    = 1'b1;
                            mem_addr  = if_addr;
                            owner_d_d = 1'b0;
                            wr_d      = 1'b0;
                            starve_d  = '0;
                        end else begin
                            d_gnt     = 1'b1;
                            mem_we    = d_we;
                            mem_wstrb = d_wstrb;
                            mem_addr  = d_addr;
                            mem_wdata = d_wdata;
                            owner_d_d = 1'b1;
                            wr_d      = d_we;
                            if (!if_req) begin
                                starve_d = '0;
                            end else if (starve_q != STARVE_W'(STARVE_MAX)) begin
                                starve_d = starve_q + STARVE_W'(1);
                            end
                        end
                    end
                end
                WAIT: begin
                    if (lat_q == '0) begin
                        state_d = IDLE;
                        if (owner_d_q) begin
                            d_rvalid = 1'b1;
                            d_rdata  = wr_q ? '0 : mem_rdata;
                        end else begin
                            if_rvalid = 1'b1;
                            if_rdata  = mem_rdata;
                        end
                    end else begin
                        lat_d = lat_q - LAT_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single unified memory port between instruction fetch and the load/store unit of the RISC-V core. Arbitrates between the two requesters and keeps one transaction in flight at a time. Sequences the fixed memory read latency and returns the response to the winner. It sits between CPU fetch/LSU and the memory array, and replaces direct inst_mem/data-mem wiring.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width; byte strobes are DATA_W/8 bits
MEM_LAT, 1, memory read latency in cycles; legal range 1..4
STARVE_MAX, 4, consecutive data grants allowed while fetch waits

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high
if_req  in  1  fetch request
if_addr  in  ADDR_W  fetch address
if_gnt  out  1  fetch request accepted this cycle
if_rvalid  out  1  fetch data valid
if_rdata  out  DATA_W  fetch data
d_req  in  1  LSU request
d_we  in  1  LSU write (1) or read (0)
d_wstrb  in  DATA_W/8  write byte strobes
d_addr  in  ADDR_W  LSU address
d_wdata  in  DATA_W  LSU write data
d_gnt  out  1  LSU request accepted this cycle
d_rvalid  out  1  LSU read data valid, or write completion
d_rdata  out  DATA_W  LSU read data
mem_en  out  1  memory access strobe
mem_we  out  1  memory write
mem_wstrb  out  DATA_W/8  memory byte strobes
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after mem_en

Behaviour:
- FSM states: IDLE and WAIT. Latency counter lat_cnt. Starvation counter starve_cnt (0..STARVE_MAX).
- IDLE with any req asserted: pick the winner and assert its gnt combinationally in that cycle (cycle T).
  - Drive mem_en=1 with the winner's addr/we/wstrb/wdata in the same cycle.
  - Fetch is a read: mem_we=0, mem_wstrb=0.
  - Next state WAIT; lat_cnt loads MEM_LAT-1; the winner id is registered.
- WAIT: lat_cnt decrements each cycle. In the cycle where lat_cnt==0 (T+MEM_LAT), assert the owner's rvalid for exactly one cycle.
  - rdata is mem_rdata passed through for reads, and 0 for writes.
  - Next state IDLE.
- Throughput: at most one grant per MEM_LAT+1 cycles. No grant is issued in WAIT.
- Arbitration priority: data wins by default. Fetch wins when starve_cnt==STARVE_MAX.
- starve_cnt updates at each arbitration:
  - +1 if data is granted while if_req=1.
  - Reset to 0 when fetch is granted.
  - Reset to 0 when arbitration happens with if_req=0.
  - Saturates at STARVE_MAX.
- Requesters hold req and payload stable until gnt. Dropping req before gnt cancels the request with no side effects. Requester inputs are don't-care after gnt.
- When no grant occurs, all mem_* outputs are 0.
- if_rdata/d_rdata are 0 whenever the corresponding rvalid=0.
- Reset (any state, including mid-WAIT):
  - Next cycle: state IDLE, lat_cnt=0, starve_cnt=0.
  - The in-flight response is discarded; no rvalid is ever emitted for it.
  - While reset=1, all outputs are 0 and no grants are issued, regardless of req inputs.
- If d_req and if_req are both asserted in WAIT, nothing is granted until the return to IDLE.
- MEM_LAT outside 1..4 is unsupported; simulation must flag it with an $error at time 0.

Test Plan:
- Fetch only (MEM_LAT=1): reset 2 cycles, then if_req=1, if_addr=0x0 with mem[0]=0x00000093 -> if_gnt=1 and mem_en=1, mem_addr=0x0 at T; if_rvalid=1, if_rdata=0x00000093 at T+1; d_gnt/d_rvalid stay 0.
- Collision: if_req=1 (addr 0x4) and d_req=1 read (addr 0x100) at the same cycle T -> d_gnt at T, d_rvalid at T+1; if_gnt at T+2, if_rvalid at T+3.
- Starvation (STARVE_MAX=4): d_req and if_req held continuously -> d_gnt at T, T+2, T+4, T+6; if_gnt at T+8; d_gnt again at T+10.
- Write then read: d_we=1, d_wstrb=0011, d_addr=0x200, d_wdata=0xDEADBEEF on zeroed memory:
  - At T: mem_we=1, mem_wstrb=0011.
  - At T+1: d_rvalid=1, d_rdata=0.
  - Read of 0x200 afterwards returns 0x0000BEEF.
- Reset mid-flight (MEM_LAT=3): grant at T, reset=1 at T+1 -> no rvalid at T+3. State is IDLE and starve_cnt=0 after reset. A new if_req is granted on the first cycle with reset=0.
- Back-to-back fetch (MEM_LAT=3): if_req held continuously -> if_gnt at T, T+4, T+8; if_rvalid at T+3, T+7, T+11; mem_en high only at grant cycles.
